// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: legal oversampling ratios,
// line levels and frame lengths, plus the prescale legality check.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  localparam int unsigned FRAME_BITS_NO_PAR = 10;
  localparam int unsigned FRAME_BITS_PAR    = 11;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/rx_bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit line; resets to the
// idle line level so a reset never looks like a start bit.
module rx_bit_sync
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb chain_d = {chain_q[SYNC_STAGES-2:0], async_i};

  always_ff @(posedge clk) begin
    if (rst) chain_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else     chain_q <= chain_d;
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_edge_sampler.sv
// UART receive oversampling front end: synchronises rx, counts edges per bit
// and bits per frame, and majority-votes three mid-bit samples into one bit.
module rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int BIT_CNT_W   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  input  logic                  cnt_en,
  input  logic                  dat_samp_en,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] mid;
  logic v0_q, v0_d, v1_q, v1_d;
  logic arm_q, arm_d;
  logic sampled_q, sampled_d;
  logic valid_q, valid_d;
  logic wrap, samp_en, at_v0, at_v1, at_vote;

  rx_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_in),
    .sync_o  (rx_sync)
  );

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    mid     = prescale_q >> 1;
    wrap    = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
    samp_en = cnt_en & dat_samp_en;
    at_v0   = (edge_cnt_q == mid - PRESCALE_W'(1));
    at_v1   = (edge_cnt_q == mid);
    at_vote = (edge_cnt_q == mid + PRESCALE_W'(1));

    prescale_d = prescale_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    arm_d      = arm_q;
    sampled_d  = sampled_q;
    valid_d    = 1'b0;

    if (!cnt_en) begin
      prescale_d = prescale_legal(32'(prescale)) ? prescale : PRESCALE_W'(PRESCALE_8);
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      arm_d      = 1'b0;
    end else begin
      if (wrap) begin
        edge_cnt_d = '0;
        bit_cnt_d  = (bit_cnt_q == frame_bits - BIT_CNT_W'(1)) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      // arm_q remembers that both earlier votes of this bit were captured
      if (at_v0) begin
        arm_d = samp_en;
        if (samp_en) v0_d = rx_sync;
      end
      if (at_v1) begin
        arm_d = arm_q & samp_en;
        if (samp_en) v1_d = rx_sync;
      end
      if (at_vote) begin
        arm_d = 1'b0;
        if (samp_en && arm_q) begin
          sampled_d = majority3(v0_q, v1_q, rx_sync);
          valid_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= PRESCALE_W'(PRESCALE_8);
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      arm_q      <= 1'b0;
      sampled_q  <= IDLE_LEVEL;
      valid_q    <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      arm_q      <= arm_d;
      sampled_q  <= sampled_d;
      valid_q    <= valid_d;
    end
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign bit_done     = cnt_en & wrap;
  assign sampled_bit  = sampled_q;
  assign sample_valid = valid_q;

endmodule

// File: doc/rx_edge_sampler.md
Name: rx_edge_sampler

Overview:
- Oversampling front end of the UART receiver.
- Synchronises the raw rx line and counts oversampling edges within each bit and bits within each frame.
- Produces one majority-voted `sampled_bit` per bit period, with a `sample_valid` strobe.
- Feeds the start-bit check, parity check and stop check stages; the rx FSM controls it via `cnt_en` and `dat_samp_en`.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt (supports up to 32x oversampling).
- BIT_CNT_W, 4, width of bit_cnt.
- SYNC_STAGES, 2, number of flops in the rx input synchroniser (minimum 2).

Ports:
- clk  in  1  receiver clock (prescale x baud).
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line, idle high.
- prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- frame_bits  in  BIT_CNT_W  bits per frame including start and stop (10 without parity, 11 with).
- cnt_en  in  1  from rx FSM: run edge/bit counters.
- dat_samp_en  in  1  from rx FSM: enable sample capture.
- rx_sync  out  1  synchronised line, for FSM idle/start detection.
- edge_cnt  out  PRESCALE_W  oversample edge index within current bit.
- bit_cnt  out  BIT_CNT_W  bit index within frame (0 = start bit).
- bit_done  out  1  high in the cycle edge_cnt == prescale_q-1 while cnt_en.
- sampled_bit  out  1  majority-voted bit value.
- sample_valid  out  1  one-cycle strobe; sampled_bit is valid in the same cycle.

Behaviour:
- **Reset** (rst=1 at clk edge): synchroniser flops=1, rx_sync=1, edge_cnt=0, bit_cnt=0, prescale_q=8, sampled_bit=1, sample_valid=0, vote regs=0. A mid-frame reset aborts everything on that edge; no strobe follows.
- **Synchroniser:** rx_sync is rx_in delayed SYNC_STAGES cycles.
- **prescale_q:**
  - Loaded from prescale on every cycle with cnt_en=0; frozen while cnt_en=1, so prescale changes mid-frame are ignored.
  - Any value other than 8, 16 or 32 loads as 8.
- **Counters while cnt_en=0:** edge_cnt and bit_cnt are cleared to 0 next edge; bit_done=0; sample_valid=0.
- **Counters while cnt_en=1:**
  - edge_cnt increments each cycle; on edge_cnt == prescale_q-1 it wraps to 0.
  - On wrap, bit_cnt increments. If bit_cnt == frame_bits-1 at wrap, bit_cnt wraps to 0.
  - bit_done is decoded from registered edge_cnt, so it is high in the wrap cycle.
- **Sampling** (mid = prescale_q>>1), all gated by cnt_en & dat_samp_en:
  - At edge_cnt == mid-1: v0 <= rx_sync.
  - At edge_cnt == mid: v1 <= rx_sync.
  - At edge_cnt == mid+1: sampled_bit <= majority(v0, v1, rx_sync) and sample_valid <= 1.
  - Result: sampled_bit and sample_valid are presented in the cycle edge_cnt == mid+2. Latency is 3 cycles from the first vote edge.
- **dat_samp_en low:** no capture and no strobe; sampled_bit holds its last value.
- **dat_samp_en dropping between vote edges:** the bit is dropped and no strobe is issued.
- **cnt_en dropping mid-bit:** counters clear next edge; a pending strobe is suppressed; sampled_bit holds.
- **sample_valid** is never high for more than one consecutive cycle.
- **Timing:** no combinational path from rx_in to any output.

Decomposition:
- Package uart_rx_pkg:
  - PRESCALE_8/16/32 constants.
  - IDLE_LEVEL=1, START_BIT=0, STOP_BIT=1.
  - FRAME_BITS_NO_PAR=10, FRAME_BITS_PAR=11.
  - prescale legality function.
- Sub-module rx_bit_sync: SYNC_STAGES-deep flop chain, reset value 1, instantiated once for rx_in.

Test Plan:
- **Reset:** hold rst=1 for 3 cycles with rx_in=0 -> rx_sync=1, edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0; rx_sync goes 0 exactly SYNC_STAGES cycles after rst release.
- **Clean frame, prescale=8, frame_bits=10:** send 0x55 (start 0, LSB first, stop 1), cnt_en and dat_samp_en high.
  - Expect 10 sample_valid pulses, each at edge_cnt==6.
  - sampled_bit sequence 0,1,0,1,0,1,0,1,0,1.
  - bit_done every 8 cycles; bit_cnt 0..9 then 0.
- **Glitch rejection, prescale=16:** data bit 1 with a single-cycle 0 at edge 7 (v0 position) -> sampled_bit=1. Two low edges (7 and 8) -> sampled_bit=0.
- **Prescale 32 and illegal value:**
  - prescale=32: first strobe at edge_cnt==18, bit_done at edge 31.
  - prescale=20 latched: behaves as 8 (strobe at edge 6, wrap at 7).
  - prescale changed 16->8 mid-frame: no effect until cnt_en drops.
- **Abort cases:**
  - cnt_en dropped at edge_cnt==mid (prescale=16) -> no strobe, edge_cnt=0 next cycle.
  - rst asserted at bit_cnt==5 -> all outputs at reset values next cycle.
- **dat_samp_en gating:** dat_samp_en=0 for bit 3 of a frame -> no strobe for that bit; sampled_bit holds bit-2 value; counters unaffected (bit_cnt still reaches 9).
